// File: rtl/uram_pkg.sv
// Shared constants and types for the dual-port URAM array.
// Lane geometry, collision policy and response-pipeline metadata.
package uram_pkg;

  localparam int LANE_W    = 72;
  localparam int BWE_W     = 9;
  localparam int ROW_DEPTH = 4096;
  localparam int ROWW      = 12;
  localparam int TAG_MAX_W = 32;

  typedef enum logic {
    COLL_A_PRIO = 1'b0,
    COLL_B_PRIO = 1'b1
  } coll_policy_e;

  // Tag is carried at full width; ports use the low TAG_W bits.
  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [TAG_MAX_W-1:0] tag;
  } uram_rsp_meta_t;

endpackage

// File: rtl/uram_para.sv
// One 72-bit true-dual-port URAM slice, CASCADE rows of 4096 words.
// Byte-write enables per port; registered read with RD_LAT latency.
module uram_para
  import uram_pkg::*;
#(
  parameter int CASCADE = 16,
  parameter int RD_LAT  = 3,
  parameter int AW      = ROWW + $clog2(CASCADE)
) (
  input  logic              clk,
  input  logic              i_en_a,
  input  logic              i_rdb_wr_a,
  input  logic [AW-1:0]     i_addr_a,
  input  logic [BWE_W-1:0]  i_bwe_a,
  input  logic [LANE_W-1:0] i_din_a,
  output logic [LANE_W-1:0] o_dout_a,
  input  logic              i_en_b,
  input  logic              i_rdb_wr_b,
  input  logic [AW-1:0]     i_addr_b,
  input  logic [BWE_W-1:0]  i_bwe_b,
  input  logic [LANE_W-1:0] i_din_b,
  output logic [LANE_W-1:0] o_dout_b
);

  localparam int DEPTH = CASCADE * ROW_DEPTH;
  localparam int BYTE  = LANE_W / BWE_W;

  logic [LANE_W-1:0] r_mem [DEPTH];
  logic [LANE_W-1:0] r_qa  [RD_LAT];
  logic [LANE_W-1:0] r_qb  [RD_LAT];

  always_ff @(posedge clk) begin
    if (i_en_a && i_rdb_wr_a) begin
      for (int j = 0; j < BWE_W; j++) begin
        if (i_bwe_a[j])
          r_mem[i_addr_a][j*BYTE +: BYTE] <= i_din_a[j*BYTE +: BYTE];
      end
    end
    if (i_en_b && i_rdb_wr_b) begin
      for (int j = 0; j < BWE_W; j++) begin
        if (i_bwe_b[j])
          r_mem[i_addr_b][j*BYTE +: BYTE] <= i_din_b[j*BYTE +: BYTE];
      end
    end
    if (i_en_a && !i_rdb_wr_a) r_qa[0] <= r_mem[i_addr_a];
    if (i_en_b && !i_rdb_wr_b) r_qb[0] <= r_mem[i_addr_b];
    for (int k = 1; k < RD_LAT; k++) begin
      r_qa[k] <= r_qa[k-1];
      r_qb[k] <= r_qb[k-1];
    end
  end

  assign o_dout_a = r_qa[RD_LAT-1];
  assign o_dout_b = r_qb[RD_LAT-1];

endmodule

// File: rtl/uram_rsp_pipe.sv
// Read-response metadata pipeline, aligned with the slice read latency.
// Reset drops in-flight reads; data is zeroed unless a clean read returns.
module uram_rsp_pipe
  import uram_pkg::*;
#(
  parameter int DW     = 576,
  parameter int TAG_W  = 8,
  parameter int RD_LAT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  uram_rsp_meta_t i_meta,
  input  logic [DW-1:0]  i_data,
  output logic           o_valid,
  output logic           o_err,
  output logic [TAG_W-1:0] o_tag,
  output logic [DW-1:0]  o_data
);

  uram_rsp_meta_t r_pipe [RD_LAT];
  logic           w_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= i_meta;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_valid = r_pipe[RD_LAT-1].valid;
  assign o_err   = o_valid && r_pipe[RD_LAT-1].err;
  assign o_tag   = o_valid ? r_pipe[RD_LAT-1].tag[TAG_W-1:0] : '0;
  assign w_ok    = o_valid && !r_pipe[RD_LAT-1].err;
  assign o_data  = w_ok ? i_data : '0;

endmodule

// File: rtl/uram_dp_array.sv
// Shared packet buffer: LANES x 72-bit URAM slices, peer port A, host port B.
// Adds handshake, same-address arbitration, range check and response tags.
module uram_dp_array
  import uram_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int CASCADE     = 16,
  parameter int ADDR_W      = 23,
  parameter int RD_LAT      = 3,
  parameter int TAG_W       = 8,
  parameter int COLL_B_WINS = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_a,
  output logic                      req_ready_a,
  input  logic                      req_wr_a,
  input  logic [ADDR_W-1:0]         req_addr_a,
  input  logic [LANES*BWE_W-1:0]    req_be_a,
  input  logic [LANES*LANE_W-1:0]   req_wdata_a,
  input  logic [TAG_W-1:0]          req_tag_a,
  input  logic                      req_valid_b,
  output logic                      req_ready_b,
  input  logic                      req_wr_b,
  input  logic [ADDR_W-1:0]         req_addr_b,
  input  logic [LANES*BWE_W-1:0]    req_be_b,
  input  logic [LANES*LANE_W-1:0]   req_wdata_b,
  input  logic [TAG_W-1:0]          req_tag_b,
  output logic                      rsp_valid_a,
  output logic [LANES*LANE_W-1:0]   rsp_data_a,
  output logic [TAG_W-1:0]          rsp_tag_a,
  output logic                      rsp_err_a,
  output logic                      rsp_valid_b,
  output logic [LANES*LANE_W-1:0]   rsp_data_b,
  output logic [TAG_W-1:0]          rsp_tag_b,
  output logic                      rsp_err_b,
  output logic [31:0]               coll_cnt
);

  localparam int DW    = LANES * LANE_W;
  localparam int DEPTH = CASCADE * ROW_DEPTH;
  localparam int MAW   = ROWW + $clog2(CASCADE);
  localparam coll_policy_e POLICY =
    (COLL_B_WINS != 0) ? COLL_B_PRIO : COLL_A_PRIO;

  logic           w_coll;
  logic           w_acc_a, w_acc_b;
  logic           w_inr_a, w_inr_b;
  logic           w_en_a, w_en_b;
  logic [DW-1:0]  w_dout_a, w_dout_b;
  uram_rsp_meta_t w_meta_a, w_meta_b;
  logic [31:0]    r_coll_cnt;

  // Read/read to one address is harmless; any write makes it a collision.
  assign w_coll = req_valid_a && req_valid_b &&
                  (req_addr_a == req_addr_b) &&
                  (req_wr_a || req_wr_b);

  assign req_ready_a = rst_n && !(w_coll && POLICY == COLL_B_PRIO);
  assign req_ready_b = rst_n && !(w_coll && POLICY == COLL_A_PRIO);

  assign w_acc_a = req_valid_a && req_ready_a;
  assign w_acc_b = req_valid_b && req_ready_b;

  assign w_inr_a = (ADDR_W+1)'(req_addr_a) < (ADDR_W+1)'(DEPTH);
  assign w_inr_b = (ADDR_W+1)'(req_addr_b) < (ADDR_W+1)'(DEPTH);

  assign w_en_a = w_acc_a && w_inr_a;
  assign w_en_b = w_acc_b && w_inr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_coll_cnt <= '0;
    else if (w_coll && r_coll_cnt != '1)
      r_coll_cnt <= r_coll_cnt + 32'd1;
  end

  assign coll_cnt = r_coll_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    uram_para #(
      .CASCADE(CASCADE),
      .RD_LAT (RD_LAT),
      .AW     (MAW)
    ) u_slice (
      .clk       (clk),
      .i_en_a    (w_en_a),
      .i_rdb_wr_a(req_wr_a),
      .i_addr_a  (req_addr_a[MAW-1:0]),
      .i_bwe_a   (req_be_a[i*BWE_W +: BWE_W]),
      .i_din_a   (req_wdata_a[i*LANE_W +: LANE_W]),
      .o_dout_a  (w_dout_a[i*LANE_W +: LANE_W]),
      .i_en_b    (w_en_b),
      .i_rdb_wr_b(req_wr_b),
      .i_addr_b  (req_addr_b[MAW-1:0]),
      .i_bwe_b   (req_be_b[i*BWE_W +: BWE_W]),
      .i_din_b   (req_wdata_b[i*LANE_W +: LANE_W]),
      .o_dout_b  (w_dout_b[i*LANE_W +: LANE_W])
    );
  end

  assign w_meta_a = '{valid: w_acc_a && !req_wr_a,
                      err:   !w_inr_a,
                      tag:   TAG_MAX_W'(req_tag_a)};
  assign w_meta_b = '{valid: w_acc_b && !req_wr_b,
                      err:   !w_inr_b,
                      tag:   TAG_MAX_W'(req_tag_b)};

  uram_rsp_pipe #(
    .DW(DW), .TAG_W(TAG_W), .RD_LAT(RD_LAT)
  ) u_rsp_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_meta (w_meta_a),
    .i_data (w_dout_a),
    .o_valid(rsp_valid_a),
    .o_err  (rsp_err_a),
    .o_tag  (rsp_tag_a),
    .o_data (rsp_data_a)
  );

  uram_rsp_pipe #(
    .DW(DW), .TAG_W(TAG_W), .RD_LAT(RD_LAT)
  ) u_rsp_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_meta (w_meta_b),
    .i_data (w_dout_b),
    .o_valid(rsp_valid_b),
    .o_err  (rsp_err_b),
    .o_tag  (rsp_tag_b),
    .o_data (rsp_data_b)
  );

endmodule

// File: tb/tb_uram_dp_array.sv
// Bench for uram_dp_array: directed steps plus random traffic on both ports,
// scored against a word-level memory model and per-port response queues.
module tb_uram_dp_array;

  localparam int LANES   = 8;
  localparam int CASCADE = 16;
  localparam int ADDR_W  = 23;
  localparam int RD_LAT  = 3;
  localparam int TAG_W   = 8;
  localparam int DEPTH   = CASCADE * 4096;
  localparam int DW      = LANES * 72;
  localparam int BEW     = LANES * 9;
  localparam bit B_WINS  = 1'b0;

  typedef struct {
    bit                v;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [BEW-1:0]    be;
    logic [DW-1:0]     data;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct {
    int               due;
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
    bit               err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid_a, req_ready_a, req_wr_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [BEW-1:0] req_be_a;
  logic [DW-1:0] req_wdata_a;
  logic [TAG_W-1:0] req_tag_a;
  logic req_valid_b, req_ready_b, req_wr_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [BEW-1:0] req_be_b;
  logic [DW-1:0] req_wdata_b;
  logic [TAG_W-1:0] req_tag_b;
  logic rsp_valid_a, rsp_err_a, rsp_valid_b, rsp_err_b;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic [TAG_W-1:0] rsp_tag_a, rsp_tag_b;
  logic [31:0] coll_cnt;

  always #5 clk = ~clk;

  uram_dp_array #(
    .LANES(LANES), .CASCADE(CASCADE), .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT), .TAG_W(TAG_W), .COLL_B_WINS(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a),
    .req_wr_a(req_wr_a), .req_addr_a(req_addr_a),
    .req_be_a(req_be_a), .req_wdata_a(req_wdata_a),
    .req_tag_a(req_tag_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b),
    .req_wr_b(req_wr_b), .req_addr_b(req_addr_b),
    .req_be_b(req_be_b), .req_wdata_b(req_wdata_b),
    .req_tag_b(req_tag_b),
    .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a),
    .rsp_tag_a(rsp_tag_a), .rsp_err_a(rsp_err_a),
    .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b),
    .rsp_tag_b(rsp_tag_b), .rsp_err_b(rsp_err_b),
    .coll_cnt(coll_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  longint model_coll = 0;
  logic [DW-1:0] mem [int];
  rsp_t qa[$];
  rsp_t qb[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic req_t idle();
    req_t r;
    r.v = 0; r.wr = 0; r.addr = '0; r.be = '0; r.data = '0; r.tag = '0;
    return r;
  endfunction

  function automatic req_t rd(input int addr, input int tag);
    req_t r = idle();
    r.v = 1; r.addr = ADDR_W'(addr); r.tag = TAG_W'(tag);
    return r;
  endfunction

  function automatic req_t wr(input int addr, input logic [BEW-1:0] be,
                              input logic [DW-1:0] d);
    req_t r = idle();
    r.v = 1; r.wr = 1; r.addr = ADDR_W'(addr); r.be = be; r.data = d;
    return r;
  endfunction

  function automatic req_t gen();
    req_t r = idle();
    r.v = ($urandom_range(0, 3) != 0);
    r.wr = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 19) == 0)
      r.addr = ADDR_W'(DEPTH + $urandom_range(0, 3));
    else
      r.addr = ADDR_W'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) r.be[i*24 +: 24] = 24'($urandom);
    if ($urandom_range(0, 2) == 0) r.be = '1;
    r.data = rnd_data();
    r.tag = TAG_W'($urandom);
    return r;
  endfunction

  // Word-level reference memory: byte k of the word follows be[k].
  function automatic void mwrite(input req_t r);
    logic [DW-1:0] w;
    int a = int'(r.addr);
    if (a >= DEPTH) return;
    w = mem.exists(a) ? mem[a] : '0;
    for (int k = 0; k < BEW; k++)
      if (r.be[k]) w[k*8 +: 8] = r.data[k*8 +: 8];
    mem[a] = w;
  endfunction

  function automatic rsp_t mread(input req_t r);
    rsp_t e;
    int a = int'(r.addr);
    e.due = cyc + RD_LAT;
    e.tag = r.tag;
    e.err = (a >= DEPTH);
    e.data = (!e.err && mem.exists(a)) ? mem[a] : '0;
    return e;
  endfunction

  task automatic chk_rsp(input bit pb);
    rsp_t e;
    bit due;
    if (!pb) begin
      due = (qa.size() > 0) && (qa[0].due == cyc);
      chk("rsp_valid_a", DW'(rsp_valid_a), DW'(due));
      if (due) begin
        e = qa.pop_front();
        chk("rsp_data_a", rsp_data_a, e.data);
        chk("rsp_tag_a", DW'(rsp_tag_a), DW'(e.tag));
        chk("rsp_err_a", DW'(rsp_err_a), DW'(e.err));
      end
    end else begin
      due = (qb.size() > 0) && (qb[0].due == cyc);
      chk("rsp_valid_b", DW'(rsp_valid_b), DW'(due));
      if (due) begin
        e = qb.pop_front();
        chk("rsp_data_b", rsp_data_b, e.data);
        chk("rsp_tag_b", DW'(rsp_tag_b), DW'(e.tag));
        chk("rsp_err_b", DW'(rsp_err_b), DW'(e.err));
      end
    end
  endtask

  task automatic step(input req_t a, input req_t b,
                      output bit acc_a, output bit acc_b);
    bit coll, ea, eb;
    @(negedge clk);
    req_valid_a = a.v; req_wr_a = a.wr; req_addr_a = a.addr;
    req_be_a = a.be; req_wdata_a = a.data; req_tag_a = a.tag;
    req_valid_b = b.v; req_wr_b = b.wr; req_addr_b = b.addr;
    req_be_b = b.be; req_wdata_b = b.data; req_tag_b = b.tag;
    #1;
    chk_rsp(0);
    chk_rsp(1);
    coll = a.v && b.v && (a.addr == b.addr) && (a.wr || b.wr);
    ea = !(coll && B_WINS);
    eb = !(coll && !B_WINS);
    chk("ready_a", DW'(req_ready_a), DW'(ea));
    chk("ready_b", DW'(req_ready_b), DW'(eb));
    acc_a = a.v && ea;
    acc_b = b.v && eb;
    if (coll && model_coll < 64'hFFFF_FFFF) model_coll++;
    if (acc_a && !a.wr) qa.push_back(mread(a));
    if (acc_b && !b.wr) qb.push_back(mread(b));
    if (acc_a && a.wr) mwrite(a);
    if (acc_b && b.wr) mwrite(b);
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    bit x, y;
    repeat (RD_LAT + 1) step(idle(), idle(), x, y);
  endtask

  task automatic chk_coll(input string tag);
    chk(tag, DW'(coll_cnt), DW'(model_coll[31:0]));
  endtask

  initial begin
    bit aa, ab;
    req_t pa, pb;
    logic [DW-1:0] d;
    rst_n = 1'b1;
    req_valid_a = 0; req_wr_a = 0; req_addr_a = '0; req_be_a = '0;
    req_wdata_a = '0; req_tag_a = '0;
    req_valid_b = 0; req_wr_b = 0; req_addr_b = '0; req_be_b = '0;
    req_wdata_b = '0; req_tag_b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rsp_valid_a", DW'(rsp_valid_a), '0);
    chk("rst_rsp_valid_b", DW'(rsp_valid_b), '0);
    chk("rst_rsp_data_a", rsp_data_a, '0);
    chk("rst_rsp_data_b", rsp_data_b, '0);
    chk("rst_rsp_tag_a", DW'(rsp_tag_a), '0);
    chk("rst_rsp_err_b", DW'(rsp_err_b), '0);
    chk("rst_coll_cnt", DW'(coll_cnt), '0);
    chk("rst_ready_a", DW'(req_ready_a), '0);
    chk("rst_ready_b", DW'(req_ready_b), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++)
      step(wr(2*i, '1, rnd_data()), wr(2*i + 1, '1, rnd_data()), aa, ab);

    // Full write on A, read on B two cycles later.
    step(wr('h10, '1, rnd_data()), idle(), aa, ab);
    step(idle(), idle(), aa, ab);
    step(idle(), rd('h10, 'h5A), aa, ab);
    drain();

    // Lane-0 partial write; other lanes keep prior contents.
    step(wr('h20, 72'h1FF, rnd_data()), idle(), aa, ab);
    step(rd('h20, 'h11), idle(), aa, ab);
    drain();

    // Write/write collision, B retries, final read returns B's data.
    d = rnd_data();
    step(wr('h30, '1, rnd_data()), wr('h30, '1, d), aa, ab);
    step(idle(), wr('h30, '1, d), aa, ab);
    step(rd('h30, 'h22), idle(), aa, ab);
    drain();
    chk_coll("coll_cnt_ww");

    // Read/read same address is not a collision.
    step(rd('h40, 'h33), rd('h40, 'h44), aa, ab);
    drain();
    chk_coll("coll_cnt_rr");

    // Out-of-range read and discarded out-of-range write.
    step(idle(), rd(DEPTH, 'h55), aa, ab);
    drain();
    step(wr(DEPTH, '1, rnd_data()), idle(), aa, ab);
    step(rd(0, 'h66), idle(), aa, ab);
    drain();

    // Reset with reads in flight drops their responses.
    step(rd(1, 'h71), idle(), aa, ab);
    step(rd(2, 'h72), idle(), aa, ab);
    step(rd(3, 'h73), idle(), aa, ab);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_a = 0;
    req_valid_b = 0;
    #1;
    chk("inrst_rsp_valid_a", DW'(rsp_valid_a), '0);
    chk("inrst_ready_a", DW'(req_ready_a), '0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_rsp_valid_a", DW'(rsp_valid_a), '0);
    @(posedge clk);
    cyc++;
    qa.delete();
    qb.delete();
    model_coll = 0;
    chk_coll("coll_cnt_after_rst");
    step(rd('h10, 'h77), idle(), aa, ab);
    drain();

    // Random traffic on a small address window to force collisions.
    pa = gen();
    pb = gen();
    for (int n = 0; n < 400; n++) begin
      step(pa, pb, aa, ab);
      if (!pa.v || aa) pa = gen();
      if (!pb.v || ab) pb = gen();
    end
    drain();
    chk_coll("coll_cnt_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
